// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PERF_W     = 32;
  localparam logic [PERF_W-1:0] PERF_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } dmem_state_e;

  // Increment that sticks at PERF_MAX instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == PERF_MAX) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/dmem_hs_fsm.sv
// Data memory req/ack handshake with timeout; reports when MEM must hold the pipe.
module dmem_hs_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic ack,
  output logic mem_busy,
  output logic dmem_req,
  output logic bus_error
);

  dmem_state_e      state;
  dmem_state_e      state_nx;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  // Last REQ cycle is the one in which the counter shows TIMEOUT-1.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; ack wins over a simultaneous timeout.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (access) state_nx = ST_REQ;
      ST_REQ: begin
        if (ack)              state_nx = ST_DONE;
        else if (timeout_hit) state_nx = ST_ERR;
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Busy covers the request cycle in IDLE and every REQ cycle.
  always_comb begin
    mem_busy = 1'b0;
    case (state)
      ST_IDLE: mem_busy = access;
      ST_REQ:  mem_busy = 1'b1;
      default: mem_busy = 1'b0;
    endcase
  end

  // Timeout counter and registered request/error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dmem_req  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      cnt       <= (state == ST_REQ && state_nx == ST_REQ) ? cnt + CNT_W'(1) : '0;
      dmem_req  <= (state_nx == ST_REQ);
      bus_error <= (state_nx == ST_ERR);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush priority encoder with saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_MemRead,
  input  logic                  ex_RegWrite,
  input  logic [REG_ADDR_W-1:0] ex_regdst,
  input  logic                  mem_Branch,
  input  logic                  mem_ALUZero,
  input  logic                  mem_MemRead,
  input  logic                  mem_MemWrite,
  input  logic                  imem_ready,
  input  logic                  dmem_ack,
  output logic                  dmem_req,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  exmem_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  bus_error,
  output logic [PERF_W-1:0]     perf_stall,
  output logic [PERF_W-1:0]     perf_flush
);

  logic              mem_access;
  logic              mem_busy;
  logic              taken;
  logic              rs_hit;
  logic              rt_hit;
  logic              load_use;
  logic              flush_evt;
  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_flush_q;

  assign mem_access = mem_MemRead | mem_MemWrite;
  assign taken      = mem_Branch & mem_ALUZero;
  assign rs_hit     = id_uses_rs & (id_rs == ex_regdst);
  assign rt_hit     = id_uses_rt & (id_rt == ex_regdst);
  // r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use   = ex_MemRead & ex_RegWrite & (ex_regdst != '0) & (rs_hit | rt_hit);

  dmem_hs_fsm #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .access    (mem_access),
    .ack       (dmem_ack),
    .mem_busy  (mem_busy),
    .dmem_req  (dmem_req),
    .bus_error (bus_error)
  );

  // Only the highest-priority active condition drives the stage controls.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    flush_evt   = 1'b0;
    if (rst) begin
      flush_evt = 1'b0;
    end else if (mem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_evt   = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_flush  = 1'b1;
    end else if (!imem_ready) begin
      pc_stall    = 1'b1;
      ifid_flush  = 1'b1;
    end
  end

  // Saturating stall-cycle and branch-flush counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_stall)  perf_stall_q <= sat_inc(perf_stall_q);
      if (flush_evt) perf_flush_q <= sat_inc(perf_flush_q);
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TIMEOUT=4).
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_regdst;
  logic        id_uses_rs, id_uses_rt, ex_MemRead, ex_RegWrite;
  logic        mem_Branch, mem_ALUZero, mem_MemRead, mem_MemWrite;
  logic        imem_ready, dmem_ack;
  logic        dmem_req, bus_error;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [31:0] perf_stall, perf_flush;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // {pc, ifid, idex, exmem stalls, ifid, idex, exmem, memwb flushes}
  wire [7:0] ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_MEM  = 8'b1111_0001;
  localparam logic [7:0] C_BR   = 8'b0000_1110;
  localparam logic [7:0] C_LU   = 8'b1100_0100;
  localparam logic [7:0] C_IMEM = 8'b1000_1000;

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_regdst(ex_regdst),
    .mem_Branch(mem_Branch), .mem_ALUZero(mem_ALUZero),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .imem_ready(imem_ready), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .bus_error(bus_error),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_MemRead = 1'b0; ex_RegWrite = 1'b0; ex_regdst = 5'd0;
    mem_Branch = 1'b0; mem_ALUZero = 1'b0; mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
    imem_ready = 1'b1; dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++;
    if (ctl !== C_NONE) begin
      $display("FAIL reset_ctl_during_rst: got %b want %b", ctl, C_NONE); n_fail++;
    end
    @(negedge clk);
    rst = 1'b0; mem_MemRead = 1'b0; #1;
    n_checks++;
    if (dut.u_fsm.state !== ST_IDLE) begin
      $display("FAIL reset_state: got %0d want %0d", dut.u_fsm.state, ST_IDLE); n_fail++;
    end
    n_checks++;
    if ({dmem_req, bus_error, ctl} !== 10'd0) begin
      $display("FAIL reset_outputs: got %b want 0", {dmem_req, bus_error, ctl}); n_fail++;
    end
    n_checks++;
    if (perf_stall !== 32'd0 || perf_flush !== 32'd0) begin
      $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_stall, perf_flush); n_fail++;
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_regdst = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; #1;
    n_checks++;
    if (ctl !== C_LU) begin $display("FAIL load_use_rs: got %b want %b", ctl, C_LU); n_fail++; end
    exp_stall++;
    @(negedge clk);
    ex_MemRead = 1'b0; ex_RegWrite = 1'b0; #1;
    n_checks++;
    if (ctl !== C_NONE) begin $display("FAIL load_use_clear: got %b want %b", ctl, C_NONE); n_fail++; end
    @(negedge clk);
    ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_regdst = 5'd0; id_rs = 5'd0; #1;
    n_checks++;
    if (ctl !== C_NONE) begin $display("FAIL load_use_r0: got %b want %b", ctl, C_NONE); n_fail++; end
    @(negedge clk);
    ex_regdst = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1; #1;
    n_checks++;
    if (ctl !== C_LU) begin $display("FAIL load_use_rt: got %b want %b", ctl, C_LU); n_fail++; end
    exp_stall++;
    @(negedge clk);
    id_uses_rt = 1'b0; #1;
    n_checks++;
    if (ctl !== C_NONE) begin $display("FAIL load_use_rt_unused: got %b want %b", ctl, C_NONE); n_fail++; end
    @(negedge clk);
    clear_inputs(); ex_MemRead = 1'b0; ex_RegWrite = 1'b1; ex_regdst = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b1; #1;
    n_checks++;
    if (ctl !== C_NONE) begin $display("FAIL load_use_not_load: got %b want %b", ctl, C_NONE); n_fail++; end
    @(negedge clk);
    clear_inputs(); #1;
    n_checks++;
    if (perf_stall !== 32'(exp_stall)) begin
      $display("FAIL load_use_perf: got %0d want %0d", perf_stall, exp_stall); n_fail++;
    end
  endtask

  task automatic test_imem();
    @(negedge clk);
    imem_ready = 1'b0; #1;
    n_checks++;
    if (ctl !== C_IMEM) begin $display("FAIL imem_wait: got %b want %b", ctl, C_IMEM); n_fail++; end
    exp_stall++;
    @(negedge clk);
    imem_ready = 1'b1; #1;
  endtask

  task automatic test_branch_vs_load_use();
    @(negedge clk);
    ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_regdst = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    mem_Branch = 1'b1; mem_ALUZero = 1'b1; imem_ready = 1'b0; #1;
    n_checks++;
    if (ctl !== C_BR) begin $display("FAIL branch_over_load_use: got %b want %b", ctl, C_BR); n_fail++; end
    exp_flush++;
    @(negedge clk);
    mem_ALUZero = 1'b0; imem_ready = 1'b1; #1;
    n_checks++;
    if (perf_flush !== 32'(exp_flush)) begin
      $display("FAIL branch_perf_flush: got %0d want %0d", perf_flush, exp_flush); n_fail++;
    end
    n_checks++;
    if (ctl !== C_LU) begin $display("FAIL branch_not_taken: got %b want %b", ctl, C_LU); n_fail++; end
    exp_stall++;
    @(negedge clk);
    clear_inputs(); #1;
  endtask

  task automatic test_mem_ack3();
    @(negedge clk);
    mem_MemWrite = 1'b1; mem_Branch = 1'b1; mem_ALUZero = 1'b1; #1;
    n_checks++;
    if (ctl !== C_MEM || dmem_req !== 1'b0) begin
      $display("FAIL ack3_idle: got %b req %b want %b req 0", ctl, dmem_req, C_MEM); n_fail++;
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      dmem_ack = (i == 3); #1;
      n_checks++;
      if (ctl !== C_MEM || dmem_req !== 1'b1) begin
        $display("FAIL ack3_req%0d: got %b req %b want %b req 1", i, ctl, dmem_req, C_MEM); n_fail++;
      end
    end
    exp_stall += 4;
    @(negedge clk);
    clear_inputs(); #1;
    n_checks++;
    if (ctl !== C_NONE || dmem_req !== 1'b0 || dut.u_fsm.state !== ST_DONE) begin
      $display("FAIL ack3_done: got %b req %b st %0d want 0 req 0 st %0d", ctl, dmem_req, dut.u_fsm.state, ST_DONE); n_fail++;
    end
    n_checks++;
    if (perf_stall !== 32'(exp_stall) || perf_flush !== 32'(exp_flush)) begin
      $display("FAIL ack3_perf: got %0d/%0d want %0d/%0d", perf_stall, perf_flush, exp_stall, exp_flush); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    // First access acked in its first REQ cycle; MemRead held across DONE.
    @(negedge clk);
    mem_MemRead = 1'b1; #1;
    n_checks++;
    if (ctl !== C_MEM) begin $display("FAIL b2b_idle1: got %b want %b", ctl, C_MEM); n_fail++; end
    @(negedge clk);
    dmem_ack = 1'b1; #1;
    n_checks++;
    if (ctl !== C_MEM || dmem_req !== 1'b1) begin
      $display("FAIL b2b_req1: got %b req %b want %b req 1", ctl, dmem_req, C_MEM); n_fail++;
    end
    @(negedge clk);
    dmem_ack = 1'b0; #1;
    n_checks++;
    if (ctl !== C_NONE || dmem_req !== 1'b0) begin
      $display("FAIL b2b_done: got %b req %b want 0 req 0", ctl, dmem_req); n_fail++;
    end
    @(negedge clk); #1;
    n_checks++;
    if (ctl !== C_MEM || dut.u_fsm.state !== ST_IDLE) begin
      $display("FAIL b2b_idle2: got %b st %0d want %b st %0d", ctl, dut.u_fsm.state, C_MEM, ST_IDLE); n_fail++;
    end
    @(negedge clk);
    dmem_ack = 1'b1; #1;
    n_checks++;
    if (ctl !== C_MEM || dmem_req !== 1'b1) begin
      $display("FAIL b2b_req2: got %b req %b want %b req 1", ctl, dmem_req, C_MEM); n_fail++;
    end
    exp_stall += 4;
    @(negedge clk);
    clear_inputs(); #1;
    n_checks++;
    if (perf_stall !== 32'(exp_stall)) begin
      $display("FAIL b2b_perf: got %0d want %0d", perf_stall, exp_stall); n_fail++;
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    @(negedge clk);
    mem_MemRead = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (dmem_req === 1'b1 && ctl === C_MEM) req_cycles++;
    end
    n_checks++;
    if (req_cycles != 4) begin $display("FAIL timeout_req_cycles: got %0d want 4", req_cycles); n_fail++; end
    exp_stall += 5;
    @(negedge clk);
    mem_MemRead = 1'b0; #1;
    n_checks++;
    if (bus_error !== 1'b1 || dmem_req !== 1'b0 || ctl !== C_NONE) begin
      $display("FAIL timeout_err: got err %b req %b ctl %b want err 1 req 0 ctl 0", bus_error, dmem_req, ctl); n_fail++;
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus_error !== 1'b0 || dut.u_fsm.cnt !== 8'd0 || dut.u_fsm.state !== ST_IDLE) begin
      $display("FAIL timeout_after: got err %b cnt %0d st %0d want 0 0 %0d", bus_error, dut.u_fsm.cnt, dut.u_fsm.state, ST_IDLE); n_fail++;
    end
    n_checks++;
    if (perf_stall !== 32'(exp_stall)) begin
      $display("FAIL timeout_perf: got %0d want %0d", perf_stall, exp_stall); n_fail++;
    end
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    mem_MemRead = 1'b1;
    @(negedge clk);
    rst = 1'b1; #1;
    n_checks++;
    if (ctl !== C_NONE || dmem_req !== 1'b1) begin
      $display("FAIL rst_in_req_during: got %b req %b want 0 req 1", ctl, dmem_req); n_fail++;
    end
    @(negedge clk);
    rst = 1'b0; mem_MemRead = 1'b0; #1;
    exp_stall = 0; exp_flush = 0;
    n_checks++;
    if (dmem_req !== 1'b0 || dut.u_fsm.state !== ST_IDLE || perf_stall !== 32'd0) begin
      $display("FAIL rst_in_req_after: got req %b st %0d perf %0d want 0 %0d 0", dmem_req, dut.u_fsm.state, perf_stall, ST_IDLE); n_fail++;
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    imem_ready = 1'b0;
    force dut.perf_stall_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.perf_stall_q;
    @(negedge clk);
    @(negedge clk);
    imem_ready = 1'b1; #1;
    n_checks++;
    if (perf_stall !== 32'hFFFF_FFFF) begin
      $display("FAIL perf_stall_saturate: got %h want ffffffff", perf_stall); n_fail++;
    end
    @(negedge clk); #1;
    n_checks++;
    if (perf_stall !== 32'hFFFF_FFFF) begin
      $display("FAIL perf_stall_hold: got %h want ffffffff", perf_stall); n_fail++;
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    mem_MemRead = 1'b1;
    test_reset();
    test_load_use();
    test_imem();
    test_branch_vs_load_use();
    test_mem_ack3();
    test_back_to_back();
    test_timeout();
    test_reset_in_req();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
